vga_sync_gen: RTL and testbench
===============================

// Module: vga_sync_gen
// PURPOSE
//  Upstream timing stage of the video pipeline. Runs on the pixel clock and generates
//  the horizontal/vertical counters that drive the raster coordinate inputs of the
//  drawing stage. Generates hsync/vsync, which also serve as the drawing stage's
//  frame-rate FSM clock.
//  Registers the drawing stage's colour back out to the DAC, blanked and aligned with sync.
// PARAMETERS
//  H_VISIBLE  640  visible pixels per line
//  H_FRONT    16   horizontal front porch (pixels)
//  H_SYNC     96   hsync pulse width (pixels)
//  H_BACK     48   horizontal back porch (pixels)
//  V_VISIBLE  480  visible lines per frame
//  V_FRONT    10   vertical front porch (lines)
//  V_SYNC     2    vsync pulse width (lines)
//  V_BACK     33   vertical back porch (lines)
//  SYNC_POL   0    active level of hsync/vsync (0 = active-low, VGA 640x480@60)
// PORTS
//  pixel_clck  in   1   25.175 MHz pixel clock; the only clock
//  reset       in   1   synchronous, active-high reset
//  red_in      in   4   colour from drawing stage, combinational from x/y_coords
//  green_in    in   4   as above
//  blue_in     in   4   as above
//  x_coords    out  10  current horizontal count (0..H_TOTAL-1)
//  y_coords    out  10  current vertical count (0..V_TOTAL-1)
//  video_on    out  1   x_coords<H_VISIBLE && y_coords<V_VISIBLE (same cycle as coords)
//  frame_tick  out  1   one-cycle pulse, registered, asserted cycle after count (0,0)
//  vga_hsync   out  1   registered hsync to connector
//  vga_vsync   out  1   registered vsync to connector; doubles as drawing FSM clock
//  vga_red     out  4   registered, blanked colour to DAC
//  vga_green   out  4   as above
//  vga_blue    out  4   as above
// BEHAVIOUR
//  - H_TOTAL = sum of H_* = 800, V_TOTAL = sum of V_* = 525; both fit in 10 bits.
//  - h_count increments every cycle; at H_TOTAL-1 it wraps to 0 and v_count increments.
//  - v_count wraps to 0 when h_count and v_count are both at their max in the same cycle.
//  - x_coords/y_coords are the counter registers directly (no extra latency).
//  - hsync_raw active when H_VISIBLE+H_FRONT <= h_count < H_VISIBLE+H_FRONT+H_SYNC (656..751).
//  - vsync_raw active when V_VISIBLE+V_FRONT <= v_count < V_VISIBLE+V_FRONT+V_SYNC (490..491);
//    vsync is line-based, so its edges coincide with h_count wrap.
//  - Output stage, 1-cycle latency: vga_hsync/vga_vsync <= raw sync at SYNC_POL level.
//    vga_* colour <= video_on ? *_in : 4'h0.
//  - Sync and colour outputs are therefore mutually aligned, one cycle behind x/y_coords.
//  - frame_tick <= (h_count==0 && v_count==0).
//  - Reset, any time including mid-line or mid-frame:
//    h_count=v_count=0; vga_hsync/vga_vsync inactive (=~SYNC_POL); vga_* colour=0;
//    frame_tick=0. Counting resumes from (0,0) on the first cycle after reset deasserts.
//  - No other state; frame timing is fully determined by the counters.
// STRUCTURE
//  - Shared header vga_timing.vh: 640x480@60 default constants, H_TOTAL/V_TOTAL,
//    sync-window start/end derivations. The drawing stage reuses it for its max-size limit.
//  - One sub-module, vga_axis_counter (params TOTAL, SYNC_START, SYNC_END, VISIBLE; in: en;
//    out: count, wrap, visible, sync_raw), instantiated twice.
//  - Horizontal instance: en=1. Vertical instance: en=horizontal wrap.
// TESTING
//  1. Reset then 800 cycles -> x_coords 0..799 then 0; y_coords 0 -> 1 exactly at the wrap.
//  2. Line 0 -> vga_hsync low for exactly 96 cycles, first low cycle is one after x_coords==656.
//  3. Full frame (420000 cycles) -> vga_vsync low 1600 cycles starting after (0,490);
//     frame_tick pulses once per 420000 cycles.
//  4. red/green/blue_in=4'hF constant -> exactly 307200 colour-nonzero cycles per frame;
//     outputs 0 through all blanking cycles.
//  5. Assert reset at (300,200) for 1 cycle -> next cycle outputs at reset values,
//     following cycle coords (0,0) -> (1,0).
//  6. Override H=8/2/2/2, V=4/1/1/1 -> H_TOTAL 14, V_TOTAL 7 wraps;
//     sync windows at h 10..11, v 5.

Source files
------------

// File: rtl/vga_sync_gen_pkg.sv
// rtl/vga_sync_gen_pkg.sv - shared 640x480@60 timing constants and derivations for the video pipeline
package vga_sync_gen_pkg;

    localparam int COORD_W = 10;

    localparam int H_VISIBLE_DEF = 640;
    localparam int H_FRONT_DEF   = 16;
    localparam int H_SYNC_DEF    = 96;
    localparam int H_BACK_DEF    = 48;
    localparam int V_VISIBLE_DEF = 480;
    localparam int V_FRONT_DEF   = 10;
    localparam int V_SYNC_DEF    = 2;
    localparam int V_BACK_DEF    = 33;
    localparam logic SYNC_POL_DEF = 1'b0;

    typedef struct packed {
        logic [3:0] red;
        logic [3:0] green;
        logic [3:0] blue;
    } rgb_t;

    function automatic int axis_total(input int visible, input int front, input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    function automatic int sync_start(input int visible, input int front);
        return visible + front;
    endfunction

    function automatic int sync_end(input int visible, input int front, input int sync);
        return visible + front + sync;
    endfunction

    // Map a raw "in sync window" flag onto the connector level.
    function automatic logic sync_level(input logic active, input logic pol);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping counter with visible and sync-window decode
module vga_axis_counter
    import vga_sync_gen_pkg::*;
#(
    parameter int TOTAL      = 800,
    parameter int SYNC_START = 656,
    parameter int SYNC_END   = 752,
    parameter int VISIBLE    = 640
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    output logic [COORD_W-1:0] count,
    output logic               wrap,
    output logic               visible,
    output logic               sync_raw
);

    localparam logic [COORD_W-1:0] LAST    = COORD_W'(TOTAL - 1);
    localparam logic [COORD_W-1:0] S_START = COORD_W'(SYNC_START);
    localparam logic [COORD_W-1:0] S_END   = COORD_W'(SYNC_END);
    localparam logic [COORD_W-1:0] VIS     = COORD_W'(VISIBLE);

    assign wrap     = en && (count == LAST);
    assign visible  = count < VIS;
    assign sync_raw = (count >= S_START) && (count < S_END);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster timing: coordinates, registered sync and blanked colour to the DAC
module vga_sync_gen
    import vga_sync_gen_pkg::*;
#(
    parameter int   H_VISIBLE = H_VISIBLE_DEF,
    parameter int   H_FRONT   = H_FRONT_DEF,
    parameter int   H_SYNC    = H_SYNC_DEF,
    parameter int   H_BACK    = H_BACK_DEF,
    parameter int   V_VISIBLE = V_VISIBLE_DEF,
    parameter int   V_FRONT   = V_FRONT_DEF,
    parameter int   V_SYNC    = V_SYNC_DEF,
    parameter int   V_BACK    = V_BACK_DEF,
    parameter logic SYNC_POL  = SYNC_POL_DEF
) (
    input  logic               pixel_clck,
    input  logic               reset,
    input  logic [3:0]         red_in,
    input  logic [3:0]         green_in,
    input  logic [3:0]         blue_in,
    output logic [COORD_W-1:0] x_coords,
    output logic [COORD_W-1:0] y_coords,
    output logic               video_on,
    output logic               frame_tick,
    output logic               vga_hsync,
    output logic               vga_vsync,
    output logic [3:0]         vga_red,
    output logic [3:0]         vga_green,
    output logic [3:0]         vga_blue
);

    localparam int H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    logic h_wrap, h_visible, h_sync_raw;
    logic v_visible, v_sync_raw, unused_v_wrap;
    rgb_t pixel_in, pixel_out;

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .SYNC_START (sync_start(H_VISIBLE, H_FRONT)),
        .SYNC_END   (sync_end(H_VISIBLE, H_FRONT, H_SYNC)),
        .VISIBLE    (H_VISIBLE)
    ) u_h_counter (
        .clk      (pixel_clck),
        .reset    (reset),
        .en       (1'b1),
        .count    (x_coords),
        .wrap     (h_wrap),
        .visible  (h_visible),
        .sync_raw (h_sync_raw)
    );

    // Vertical axis advances once per line, so its sync edges land on the line wrap.
    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .SYNC_START (sync_start(V_VISIBLE, V_FRONT)),
        .SYNC_END   (sync_end(V_VISIBLE, V_FRONT, V_SYNC)),
        .VISIBLE    (V_VISIBLE)
    ) u_v_counter (
        .clk      (pixel_clck),
        .reset    (reset),
        .en       (h_wrap),
        .count    (y_coords),
        .wrap     (unused_v_wrap),
        .visible  (v_visible),
        .sync_raw (v_sync_raw)
    );

    assign video_on = h_visible && v_visible;
    assign pixel_in = '{red: red_in, green: green_in, blue: blue_in};

    always_ff @(posedge pixel_clck) begin
        if (reset) begin
            vga_hsync  <= ~SYNC_POL;
            vga_vsync  <= ~SYNC_POL;
            pixel_out  <= '0;
            frame_tick <= 1'b0;
        end else begin
            vga_hsync  <= sync_level(h_sync_raw, SYNC_POL);
            vga_vsync  <= sync_level(v_sync_raw, SYNC_POL);
            pixel_out  <= video_on ? pixel_in : '0;
            frame_tick <= (x_coords == '0) && (y_coords == '0);
        end
    end

    assign vga_red   = pixel_out.red;
    assign vga_green = pixel_out.green;
    assign vga_blue  = pixel_out.blue;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - randomized self-checking bench for vga_sync_gen (default and reduced timing)
module tb_vga_sync_gen;

    int p_hv [2] = '{640, 8};
    int p_hf [2] = '{16, 2};
    int p_hs [2] = '{96, 2};
    int p_hb [2] = '{48, 2};
    int p_vv [2] = '{480, 4};
    int p_vf [2] = '{10, 1};
    int p_vs [2] = '{2, 1};
    int p_vb [2] = '{33, 1};
    string tag [2] = '{"A", "B"};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [2];
    logic [3:0] ri [2], gi [2], bi [2];
    logic [9:0] xo [2], yo [2];
    logic       von [2], fto [2], hso [2], vso [2];
    logic [3:0] ro [2], go [2], bo [2];

    vga_sync_gen u_dut_a (
        .pixel_clck (clk),     .reset     (rst[0]),
        .red_in     (ri[0]),   .green_in  (gi[0]),  .blue_in   (bi[0]),
        .x_coords   (xo[0]),   .y_coords  (yo[0]),  .video_on  (von[0]),
        .frame_tick (fto[0]),  .vga_hsync (hso[0]), .vga_vsync (vso[0]),
        .vga_red    (ro[0]),   .vga_green (go[0]),  .vga_blue  (bo[0])
    );

    vga_sync_gen #(
        .H_VISIBLE (8), .H_FRONT (2), .H_SYNC (2), .H_BACK (2),
        .V_VISIBLE (4), .V_FRONT (1), .V_SYNC (1), .V_BACK (1),
        .SYNC_POL  (1'b0)
    ) u_dut_b (
        .pixel_clck (clk),     .reset     (rst[1]),
        .red_in     (ri[1]),   .green_in  (gi[1]),  .blue_in   (bi[1]),
        .x_coords   (xo[1]),   .y_coords  (yo[1]),  .video_on  (von[1]),
        .frame_tick (fto[1]),  .vga_hsync (hso[1]), .vga_vsync (vso[1]),
        .vga_red    (ro[1]),   .vga_green (go[1]),  .vga_blue  (bo[1])
    );

    // Reference: raster position as a linear pixel index, outputs from the timing rules.
    int         mh [2], mv [2];
    bit         mvalid [2] = '{1'b0, 1'b0};
    logic       ehs [2], evs [2], eft [2];
    logic [3:0] er [2], eg [2], eb [2];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i);
        int ht, vt, p, hs0, vs0;
        bit vis;
        ht  = p_hv[i] + p_hf[i] + p_hs[i] + p_hb[i];
        vt  = p_vv[i] + p_vf[i] + p_vs[i] + p_vb[i];
        hs0 = p_hv[i] + p_hf[i];
        vs0 = p_vv[i] + p_vf[i];
        if (rst[i] === 1'b1) begin
            mh[i] = 0; mv[i] = 0;
            ehs[i] = 1'b1; evs[i] = 1'b1; eft[i] = 1'b0;
            er[i] = 4'h0; eg[i] = 4'h0; eb[i] = 4'h0;
            mvalid[i] = 1'b1;
        end else if (mvalid[i]) begin
            ehs[i] = !(mh[i] >= hs0 && mh[i] < hs0 + p_hs[i]);
            evs[i] = !(mv[i] >= vs0 && mv[i] < vs0 + p_vs[i]);
            vis    = (mh[i] < p_hv[i]) && (mv[i] < p_vv[i]);
            er[i]  = vis ? ri[i] : 4'h0;
            eg[i]  = vis ? gi[i] : 4'h0;
            eb[i]  = vis ? bi[i] : 4'h0;
            eft[i] = (mh[i] == 0) && (mv[i] == 0);
            p      = (mv[i] * ht + mh[i] + 1) % (ht * vt);
            mh[i]  = p % ht;
            mv[i]  = p / ht;
        end
    endtask

    task automatic check_inst(input int i);
        if (!mvalid[i]) return;
        chk({tag[i], " x_coords"},   32'(xo[i]),  32'(mh[i]));
        chk({tag[i], " y_coords"},   32'(yo[i]),  32'(mv[i]));
        chk({tag[i], " video_on"},   32'(von[i]), 32'((mh[i] < p_hv[i]) && (mv[i] < p_vv[i])));
        chk({tag[i], " vga_hsync"},  32'(hso[i]), 32'(ehs[i]));
        chk({tag[i], " vga_vsync"},  32'(vso[i]), 32'(evs[i]));
        chk({tag[i], " frame_tick"}, 32'(fto[i]), 32'(eft[i]));
        chk({tag[i], " vga_red"},    32'(ro[i]),  32'(er[i]));
        chk({tag[i], " vga_green"},  32'(go[i]),  32'(eg[i]));
        chk({tag[i], " vga_blue"},   32'(bo[i]),  32'(eb[i]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        check_inst(0);
        check_inst(1);
    endtask

    task automatic rand_colour(input int i);
        ri[i] = 4'($urandom);
        gi[i] = 4'($urandom);
        bi[i] = 4'($urandom);
    endtask

    int   hs_low, first_low_x, ft_cnt, vs_low, nz_cnt;
    logic [9:0] prev_x;

    initial begin
        rst[0] = 1'b1; rst[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ri[i] = 4'h0; gi[i] = 4'h0; bi[i] = 4'h0;
        end
        @(negedge clk);
        repeat (3) tick();

        chk("A reset x",     32'(xo[0]),  32'd0);
        chk("A reset y",     32'(yo[0]),  32'd0);
        chk("A reset hsync", 32'(hso[0]), 32'd1);
        chk("A reset vsync", 32'(vso[0]), 32'd1);
        chk("A reset tick",  32'(fto[0]), 32'd0);
        chk("A reset red",   32'(ro[0]),  32'd0);

        rst[0] = 1'b0; rst[1] = 1'b0;
        hs_low = 0; first_low_x = -1;
        for (int n = 0; n < 2400; n++) begin
            rand_colour(0);
            rand_colour(1);
            rst[1] = ($urandom_range(0, 99) == 0);
            rst[0] = (n == 1100);
            prev_x = xo[0];
            tick();
            if (n < 800 && hso[0] == 1'b0) begin
                if (hs_low == 0) first_low_x = int'(prev_x);
                hs_low++;
            end
            if (n == 798) begin
                chk("A x at line end", 32'(xo[0]), 32'd799);
                chk("A y at line end", 32'(yo[0]), 32'd0);
            end
            if (n == 799) begin
                chk("A x after wrap", 32'(xo[0]), 32'd0);
                chk("A y after wrap", 32'(yo[0]), 32'd1);
            end
            if (n == 1099) begin
                chk("A pre-reset x", 32'(xo[0]), 32'd300);
                chk("A pre-reset y", 32'(yo[0]), 32'd1);
            end
            if (n == 1100) begin
                chk("A midline reset x",     32'(xo[0]), 32'd0);
                chk("A midline reset y",     32'(yo[0]), 32'd0);
                chk("A midline reset hsync", 32'(hso[0]), 32'd1);
                chk("A midline reset blue",  32'(bo[0]), 32'd0);
            end
            if (n == 1101) chk("A resume x", 32'(xo[0]), 32'd1);
        end
        chk("A line0 hsync low cycles", 32'(hs_low), 32'd96);
        chk("A line0 first low after x", 32'(first_low_x), 32'd656);

        // Reduced timing: three whole 14x7 frames of full-white input.
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        ri[1] = 4'hF; gi[1] = 4'hF; bi[1] = 4'hF;
        ft_cnt = 0; vs_low = 0; nz_cnt = 0;
        for (int n = 0; n < 3 * 98; n++) begin
            rand_colour(0);
            tick();
            if (fto[1]) ft_cnt++;
            if (!vso[1]) vs_low++;
            if (ro[1] != 4'h0) nz_cnt++;
            if (n == 13) chk("B h wrap y", 32'(yo[1]), 32'd1);
            if (n == 97) chk("B v wrap y", 32'(yo[1]), 32'd0);
        end
        chk("B frame_tick count", 32'(ft_cnt), 32'd3);
        chk("B vsync low cycles", 32'(vs_low), 32'd42);
        chk("B nonzero colour cycles", 32'(nz_cnt), 32'd96);

        for (int n = 0; n < 3000; n++) begin
            rand_colour(0);
            rand_colour(1);
            rst[1] = ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
